issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4: multiplier issue-to-CDB latency in cycles; pipelined unit.
REQ-002 SHALL have parameter DIV_LAT, default 8: divider issue-to-CDB latency in cycles; unpipelined unit; legal only if DIV_LAT > MULT_LAT > 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: flush request from the retire bus.
REQ-006 SHALL have ports int_issue_rdy, mem_issue_rdy, mult_issue_rdy and div_issue_rdy, each input, 1 bit: the matching reservation station holds a ready instruction.
REQ-007 SHALL have ports int_issue_done, mem_issue_done, mult_issue_done and div_issue_done, each output, 1 bit: grant; the station pops its entry this cycle.
REQ-008 SHALL have port div_busy, output, 1 bit: divider occupied.
REQ-009 SHALL have port cdb_valid, output, 1 bit: a unit drives the CDB this cycle.
REQ-010 SHALL have port cdb_src, output, 2 bits: CDB owner this cycle, encoded as INT_FIFO=0, LD_ST_FIFO=1, MULT_FIFO=2, DIV_FIFO=3.

Function
REQ-011 SHALL keep a CDB reservation shift register res[1..DIV_LAT], each entry holding a valid bit and a 2-bit source.
REQ-012 SHALL, every cycle, load res[k] from res[k+1]; res[DIV_LAT] loads invalid unless it is newly written.
REQ-013 SHALL drive cdb_valid = res[1].valid and cdb_src = res[1].src, both registered.
REQ-014 SHALL use latency L=1 for INT and LD_ST, L=MULT_LAT for MULT, and L=DIV_LAT for DIV.
REQ-015 SHALL treat a grant of latency L in cycle t as writing res[L] at the end of t, so that the CDB slot occurs in cycle t+L.
REQ-016 SHALL grant a unit of latency L only if res[L+1] is invalid in cycle t; res[DIV_LAT+1] always counts as invalid.
REQ-017 SHALL drive grant (done) outputs combinationally from the rdy inputs and current state, in the same cycle.
REQ-018 SHALL assert no done output for a unit whose rdy input is low.
REQ-019 SHALL allow up to three grants per cycle: one of INT/LD_ST, plus MULT, plus DIV, because their target slots are distinct.
REQ-020 SHALL never grant INT and LD_ST in the same cycle.
REQ-021 SHALL resolve an INT vs LD_ST conflict with a one-bit LRU pointer: grant the least recently granted unit, then point the LRU at the other unit.
REQ-022 SHALL leave the LRU pointer unchanged when neither INT nor LD_ST is granted.
REQ-023 SHALL grant DIV only when div_busy=0.
REQ-024 SHALL set div_busy on a DIV grant and hold it through cycle t+DIV_LAT (cycles t+1..t+DIV_LAT), using a down-counter.
REQ-025 SHALL allow the earliest next DIV grant in cycle t+DIV_LAT+1.
REQ-026 SHALL accept a MULT grant every cycle, provided REQ-016 holds.
REQ-027 SHALL, while flush=1, force all done outputs to 0.
REQ-028 SHALL, when flush=1, clear every res entry and the div counter at the next edge, so cdb_valid=0 and div_busy=0 from the following cycle; the LRU pointer is unchanged.
REQ-029 SHALL keep the CDB output of a cycle in which flush=1 as its current registered value.
REQ-030 SHALL never drive two sources onto one CDB slot; the bench asserts this invariant.

Reset
REQ-031 SHALL, with rst high, asynchronously clear all res entries, the div counter and the LRU pointer (LRU=0 favours INT).
REQ-032 SHALL hold cdb_valid=0, cdb_src=0 and div_busy=0 while rst is high.
REQ-033 SHALL hold all done outputs at 0 while rst is high, regardless of rdy inputs.
REQ-034 SHALL, on rst assertion mid-operation, discard all in-flight reservations and raise no CDB slot for them after reset release.

Verification
REQ-035 SHALL cover: int_issue_rdy=1 alone in cycle 0 -> int_issue_done=1 in cycle 0; cdb_valid=1 with cdb_src=0 in cycle 1.
REQ-036 SHALL cover: int_issue_rdy and mem_issue_rdy both held from cycle 0 after reset -> INT granted in cycle 0, LD_ST in cycle 1, INT in cycle 2; CDB sources 0,1,0 in cycles 1-3.
REQ-037 SHALL cover: MULT grant in cycle 0, then int_issue_rdy=1 from cycle 3 -> INT blocked in cycle 3 and granted in cycle 4; CDB shows src 2 in cycle 4 and src 0 in cycle 5.
REQ-038 SHALL cover: div_issue_rdy held from cycle 0 -> DIV grants in cycles 0 and 9; div_busy=1 in cycles 1-8; CDB src 3 in cycles 8 and 17.
REQ-039 SHALL cover: MULT grant in cycle 0 with flush=1 in cycle 2 -> cdb_valid=0 in cycles 3-5; all done outputs 0 in cycle 2.
REQ-040 SHALL cover: DIV grant in cycle 0 with rst pulsed in cycle 3 -> div_busy=0 and cdb_valid=0 immediately, and no CDB slot in cycle 8.

Source files
------------

// File: rtl/issue_scheduler.sv
// Issue scheduler: grants the four reservation stations against a CDB
// reservation shift register so that no two units ever share a CDB slot.
module issue_scheduler #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       int_issue_rdy,
    input  logic       mem_issue_rdy,
    input  logic       mult_issue_rdy,
    input  logic       div_issue_rdy,
    output logic       int_issue_done,
    output logic       mem_issue_done,
    output logic       mult_issue_done,
    output logic       div_issue_done,
    output logic       div_busy,
    output logic       cdb_valid,
    output logic [1:0] cdb_src
);

    typedef enum logic [1:0] {
        INT_FIFO   = 2'd0,
        LD_ST_FIFO = 2'd1,
        MULT_FIFO  = 2'd2,
        DIV_FIFO   = 2'd3
    } cdb_src_e;

    localparam int CW = $clog2(DIV_LAT + 1);

    logic [DIV_LAT:1]       res_valid_q, res_valid_d;
    logic [DIV_LAT:1][1:0]  res_src_q, res_src_d;
    logic [CW-1:0]          div_cnt_q, div_cnt_d;
    logic                   lru_q, lru_d;

    // Slot DIV_LAT+1 does not exist and therefore never blocks a grant.
    logic [DIV_LAT+1:1]     valid_ext;
    assign valid_ext = {1'b0, res_valid_q};

    logic issue_ok, alu_free, mult_free, div_free;
    logic int_grant, mem_grant, mult_grant, div_grant;

    always_comb begin
        issue_ok  = !rst && !flush;
        alu_free  = !valid_ext[2];
        mult_free = !valid_ext[MULT_LAT+1];
        div_free  = !valid_ext[DIV_LAT+1] && (div_cnt_q == '0);

        // LRU=0 favours INT when both single-cycle stations compete.
        int_grant  = issue_ok && alu_free && int_issue_rdy && (!mem_issue_rdy || !lru_q);
        mem_grant  = issue_ok && alu_free && mem_issue_rdy && (!int_issue_rdy ||  lru_q);
        mult_grant = issue_ok && mult_free && mult_issue_rdy;
        div_grant  = issue_ok && div_free && div_issue_rdy;
    end

    assign int_issue_done  = int_grant;
    assign mem_issue_done  = mem_grant;
    assign mult_issue_done = mult_grant;
    assign div_issue_done  = div_grant;

    assign div_busy  = (div_cnt_q != '0);
    assign cdb_valid = res_valid_q[1];
    assign cdb_src   = res_src_q[1];

    // NOTE: every next-state variable gets a default first so no path leaves
    // it unassigned; otherwise always_comb would infer a latch.
    always_comb begin
        res_valid_d = '0;
        res_src_d   = '0;
        for (int k = 1; k < DIV_LAT; k++) begin
            res_valid_d[k] = res_valid_q[k+1];
            res_src_d[k]   = res_src_q[k+1];
        end

        if (int_grant) begin
            res_valid_d[1] = 1'b1;
            res_src_d[1]   = INT_FIFO;
        end else if (mem_grant) begin
            res_valid_d[1] = 1'b1;
            res_src_d[1]   = LD_ST_FIFO;
        end
        if (mult_grant) begin
            res_valid_d[MULT_LAT] = 1'b1;
            res_src_d[MULT_LAT]   = MULT_FIFO;
        end
        if (div_grant) begin
            res_valid_d[DIV_LAT] = 1'b1;
            res_src_d[DIV_LAT]   = DIV_FIFO;
        end

        div_cnt_d = div_cnt_q;
        if (div_grant)
            div_cnt_d = CW'(DIV_LAT);
        else if (div_cnt_q != '0)
            div_cnt_d = div_cnt_q - CW'(1);

        lru_d = lru_q;
        if (int_grant)
            lru_d = 1'b1;
        else if (mem_grant)
            lru_d = 1'b0;

        // Flush drops every in-flight reservation but keeps arbitration history.
        if (flush) begin
            res_valid_d = '0;
            res_src_d   = '0;
            div_cnt_d   = '0;
        end
    end

    // NOTE: the reservation register is reset in full because its valid bits
    // directly drive the CDB; a stale bit after reset would fake a result.
    // Sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= '0;
            res_src_q   <= '0;
            div_cnt_q   <= '0;
            lru_q       <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_src_q   <= res_src_d;
            div_cnt_q   <= div_cnt_d;
            lru_q       <= lru_d;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: per-scenario directed checks plus a
// CDB slot scoreboard fed from observed grants.
module tb_issue_scheduler;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       int_rdy = 1'b0, mem_rdy = 1'b0, mult_rdy = 1'b0, div_rdy = 1'b0;
    logic       int_done, mem_done, mult_done, div_done;
    logic       div_busy, cdb_valid;
    logic [1:0] cdb_src;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Expected CDB owner keyed by absolute cycle number.
    logic [1:0] sched [int];

    issue_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .int_issue_rdy  (int_rdy),
        .mem_issue_rdy  (mem_rdy),
        .mult_issue_rdy (mult_rdy),
        .div_issue_rdy  (div_rdy),
        .int_issue_done (int_done),
        .mem_issue_done (mem_done),
        .mult_issue_done(mult_done),
        .div_issue_done (div_done),
        .div_busy       (div_busy),
        .cdb_valid      (cdb_valid),
        .cdb_src        (cdb_src)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic sb_push(input int key, input logic [1:0] src);
        vecs++;
        if (sched.exists(key)) begin
            errs++;
            $display("FAIL sb_collision cyc=%0d: slot %0d already owned by src %0d, new src %0d",
                     cyc, key, sched[key], src);
        end else begin
            sched[key] = src;
        end
    endtask

    // Scoreboard: grants seen now predict CDB ownership L cycles later.
    always @(negedge clk) begin
        if (rst) begin
            sched.delete();
        end else begin
            vecs++;
            if (sched.exists(cyc)) begin
                if (cdb_valid !== 1'b1 || cdb_src !== sched[cyc]) begin
                    errs++;
                    $display("FAIL sb_cdb cyc=%0d: got valid=%b src=%0d, expected valid=1 src=%0d",
                             cyc, cdb_valid, cdb_src, sched[cyc]);
                end
                sched.delete(cyc);
            end else if (cdb_valid !== 1'b0) begin
                errs++;
                $display("FAIL sb_cdb_idle cyc=%0d: got valid=%b, expected valid=0", cyc, cdb_valid);
            end

            vecs++;
            if ((int_done && mem_done) || (int_done && !int_rdy) || (mem_done && !mem_rdy) ||
                (mult_done && !mult_rdy) || (div_done && !div_rdy)) begin
                errs++;
                $display("FAIL sb_grant_legal cyc=%0d: got done=%b%b%b%b for rdy=%b%b%b%b",
                         cyc, int_done, mem_done, mult_done, div_done,
                         int_rdy, mem_rdy, mult_rdy, div_rdy);
            end

            if (flush) begin
                vecs++;
                if ({int_done, mem_done, mult_done, div_done} !== 4'b0000) begin
                    errs++;
                    $display("FAIL sb_flush_done cyc=%0d: got done=%b%b%b%b, expected 0000",
                             cyc, int_done, mem_done, mult_done, div_done);
                end
                sched.delete();
            end else begin
                if (int_done)  sb_push(cyc + 1, 2'd0);
                if (mem_done)  sb_push(cyc + 1, 2'd1);
                if (mult_done) sb_push(cyc + MULT_LAT, 2'd2);
                if (div_done)  sb_push(cyc + DIV_LAT, 2'd3);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy(input logic [3:0] v);
        {int_rdy, mem_rdy, mult_rdy, div_rdy} = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        set_rdy(4'b0000);
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Per-cycle directed comparison of grants, CDB and div_busy.
    task automatic expect_cycle(input string name, input int t, input logic [3:0] exp_done,
                                input logic exp_cv, input logic [1:0] exp_src, input logic exp_busy);
        vecs++;
        if ({int_done, mem_done, mult_done, div_done} !== exp_done) begin
            errs++;
            $display("FAIL %s_done t=%0d: got %b, expected %b", name, t,
                     {int_done, mem_done, mult_done, div_done}, exp_done);
        end
        vecs++;
        if (cdb_valid !== exp_cv || (exp_cv && cdb_src !== exp_src)) begin
            errs++;
            $display("FAIL %s_cdb t=%0d: got valid=%b src=%0d, expected valid=%b src=%0d",
                     name, t, cdb_valid, cdb_src, exp_cv, exp_src);
        end
        vecs++;
        if (div_busy !== exp_busy) begin
            errs++;
            $display("FAIL %s_busy t=%0d: got %b, expected %b", name, t, div_busy, exp_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_rdy(4'b1111);
        @(negedge clk);
        expect_cycle("reset", 0, 4'b0000, 1'b0, 2'd0, 1'b0);
        vecs++;
        if (cdb_src !== 2'd0) begin
            errs++;
            $display("FAIL reset_src: got %0d, expected 0", cdb_src);
        end
        next_cycle();
        set_rdy(4'b0000);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_int();
        do_reset();
        for (int t = 0; t < 3; t++) begin
            set_rdy(t == 0 ? 4'b1000 : 4'b0000);
            @(negedge clk);
            expect_cycle("single_int", t, (t == 0) ? 4'b1000 : 4'b0000, t == 1, 2'd0, 1'b0);
            next_cycle();
        end
    endtask

    task automatic test_lru();
        logic [3:0] exp_done;
        do_reset();
        for (int t = 0; t < 5; t++) begin
            set_rdy(t < 3 ? 4'b1100 : 4'b0000);
            @(negedge clk);
            exp_done = (t == 0 || t == 2) ? 4'b1000 : (t == 1) ? 4'b0100 : 4'b0000;
            expect_cycle("lru", t, exp_done, t >= 1 && t <= 3, (t == 2) ? 2'd1 : 2'd0, 1'b0);
            next_cycle();
        end
    endtask

    task automatic test_mult_block();
        logic [3:0] exp_done;
        do_reset();
        for (int t = 0; t < 7; t++) begin
            set_rdy({(t == 3 || t == 4), 1'b0, (t == 0), 1'b0});
            @(negedge clk);
            exp_done = (t == 0) ? 4'b0010 : (t == 4) ? 4'b1000 : 4'b0000;
            expect_cycle("mult_block", t, exp_done, t == 4 || t == 5, (t == 4) ? 2'd2 : 2'd0, 1'b0);
            next_cycle();
        end
    endtask

    task automatic test_mult_back_to_back();
        do_reset();
        for (int t = 0; t < 9; t++) begin
            set_rdy(t < 4 ? 4'b0010 : 4'b0000);
            @(negedge clk);
            expect_cycle("mult_b2b", t, (t < 4) ? 4'b0010 : 4'b0000, t >= 4 && t <= 7, 2'd2, 1'b0);
            next_cycle();
        end
    endtask

    task automatic test_div();
        do_reset();
        for (int t = 0; t < 19; t++) begin
            set_rdy(t <= 9 ? 4'b0001 : 4'b0000);
            @(negedge clk);
            expect_cycle("div", t, (t == 0 || t == 9) ? 4'b0001 : 4'b0000, t == 8 || t == 17, 2'd3,
                         (t >= 1 && t <= 8) || (t >= 10 && t <= 17));
            next_cycle();
        end
    endtask

    task automatic test_triple();
        logic       exp_cv;
        logic [1:0] exp_src;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            set_rdy(t == 0 ? 4'b1011 : 4'b0000);
            @(negedge clk);
            exp_cv  = (t == 1 || t == 4 || t == 8);
            exp_src = (t == 1) ? 2'd0 : (t == 4) ? 2'd2 : 2'd3;
            expect_cycle("triple", t, (t == 0) ? 4'b1011 : 4'b0000, exp_cv, exp_src, t >= 1 && t <= 8);
            next_cycle();
        end
    endtask

    task automatic test_flush();
        logic [3:0] exp_done;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            flush = (t == 2);
            set_rdy((t == 0) ? 4'b0011 : (t == 2) ? 4'b1111 : 4'b0000);
            @(negedge clk);
            exp_done = (t == 0) ? 4'b0011 : 4'b0000;
            expect_cycle("flush", t, exp_done, 1'b0, 2'd0, t == 1 || t == 2);
            next_cycle();
        end
        flush = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic [3:0] exp_done;
        do_reset();
        for (int t = 0; t < 15; t++) begin
            rst = (t == 3);
            set_rdy((t == 0 || t == 3 || t == 5) ? 4'b0001 : 4'b0000);
            if (t == 3) begin
                #1;
                vecs++;
                if (div_busy !== 1'b0 || cdb_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL rst_mid_async: got busy=%b cdb_valid=%b, expected 0 0",
                             div_busy, cdb_valid);
                end
            end
            @(negedge clk);
            exp_done = (t == 0 || t == 5) ? 4'b0001 : 4'b0000;
            expect_cycle("rst_mid", t, exp_done, t == 13, 2'd3,
                         (t >= 1 && t <= 2) || (t >= 6 && t <= 13));
            next_cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        next_cycle();
        test_reset();
        test_single_int();
        test_lru();
        test_mult_block();
        test_mult_back_to_back();
        test_div();
        test_triple();
        test_flush();
        test_rst_mid();
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
